// File: rtl/alu_issue_sequencer.sv
// ALU issue sequencer: in-order request FIFO feeding a handshake-less ALU.
// Optional: define ALU_DIV0_TRAP_EN to reject integer divide-by-zero.
module alu_issue_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [31:0]              req_data1_i,
  input  logic [31:0]              req_data2_i,
  input  logic                     req_type_i,
  input  logic [2:0]               req_op_i,
  input  logic [TAG_W-1:0]         req_tag_i,
  output logic [31:0]              alu_data1_o,
  output logic [31:0]              alu_data2_o,
  output logic                     alu_type_o,
  output logic [2:0]               alu_ctrl_o,
  input  logic [31:0]              alu_data_i,
  input  logic                     alu_zero_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_zero_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
  output logic                     rsp_err_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]      d1;
    logic [31:0]      d2;
    logic             typ;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t           state, state_nxt;
  req_t             mem [DEPTH];
  req_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [TAG_W-1:0] tag_q;
  logic             push, pop;
  logic             op_ok, trap;
  logic             issue, reject;

  assign head        = mem[rd_ptr];
  assign req_ready_o = (count < CW'(DEPTH));
  assign count_o     = count;
  assign push        = req_valid_i && req_ready_o;
  assign pop         = (state == IDLE) && (count != '0);

  always_comb begin
    op_ok = 1'b0;
    unique case (head.op)
      3'b001, 3'b010,
      3'b011, 3'b100: op_ok = 1'b1;
      default:        op_ok = 1'b0;
    endcase
  end

`ifdef ALU_DIV0_TRAP_EN
  assign trap = head.typ && (head.op == 3'b100) &&
                (head.d2 == 32'd0);
`else
  assign trap = 1'b0;
`endif

  assign issue  = pop && op_ok && !trap;
  assign reject = pop && !issue;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (issue)
          state_nxt = ISSUE;
        else if (reject)
          state_nxt = RESP;
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  state_nxt = RESP;
      RESP: begin
        if (rsp_ready_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= '{d1:  req_data1_i,
                       d2:  req_data2_i,
                       typ: req_type_i,
                       op:  req_op_i,
                       tag: req_tag_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_data1_o <= '0;
      alu_data2_o <= '0;
      alu_type_o  <= 1'b0;
      alu_ctrl_o  <= 3'b000;
      tag_q       <= '0;
    end else if (issue) begin
      alu_data1_o <= head.d1;
      alu_data2_o <= head.d2;
      alu_type_o  <= head.typ;
      alu_ctrl_o  <= head.op;
      tag_q       <= head.tag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_zero_o  <= 1'b0;
      rsp_tag_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else if (state == WAIT) begin
      rsp_valid_o <= 1'b1;
      rsp_data_o  <= alu_data_i;
      rsp_zero_o  <= alu_zero_i;
      rsp_tag_o   <= tag_q;
      rsp_err_o   <= 1'b0;
    end else if (reject) begin
      rsp_valid_o <= 1'b1;
      rsp_data_o  <= trap ? 32'hFFFF_FFFF : 32'd0;
      rsp_zero_o  <= 1'b0;
      rsp_tag_o   <= head.tag;
      rsp_err_o   <= 1'b1;
    end else if (state == RESP && rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a registered ALU model.
// Define ALU_DIV0_TRAP_EN to match a trap-enabled build.
module tb_alu_issue_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_d1 = '0;
  logic [31:0] req_d2 = '0;
  logic        req_type = 1'b0;
  logic [2:0]  req_op = '0;
  logic [4:0]  req_tag = '0;
  logic [31:0] alu_d1, alu_d2;
  logic        alu_type;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_res = '0;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic [4:0]  rsp_tag;
  logic        rsp_err;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_sequencer #(.DEPTH(4), .TAG_W(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data1_i(req_d1), .req_data2_i(req_d2),
    .req_type_i(req_type), .req_op_i(req_op),
    .req_tag_i(req_tag),
    .alu_data1_o(alu_d1), .alu_data2_o(alu_d2),
    .alu_type_o(alu_type), .alu_ctrl_o(alu_ctrl),
    .alu_data_i(alu_res), .alu_zero_i(alu_zero),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero),
    .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err),
    .count_o(count)
  );

  // ALU samples its inputs on every rising edge.
  always @(posedge clk) begin
    case (alu_ctrl)
      3'b001:  alu_res <= alu_d1 + alu_d2;
      3'b010:  alu_res <= alu_d1 - alu_d2;
      3'b011:  alu_res <= alu_d1 * alu_d2;
      3'b100:  alu_res <= (alu_d2 == 0) ? 32'hFFFF_FFFF
                                        : alu_d1 / alu_d2;
      default: alu_res <= '0;
    endcase
  end
  assign alu_zero = (alu_res == 32'd0) && !alu_type ? 1'b1
                  : (alu_res == 32'd0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic t, input logic [2:0] op,
                      input logic [4:0] tg);
    req_d1 = a; req_d2 = b; req_type = t;
    req_op = op; req_tag = tg; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int i;
    i = 0;
    lat = -1;
    while (lat < 0 && i < 20) begin
      step();
      i++;
      if (rsp_valid) lat = i;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b exp 0", rsp_valid);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", count);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %0b exp 1", req_ready);
    end
    checks++;
    if (alu_ctrl !== 3'b000 || alu_d1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_alu got ctrl %0b d1 %0h exp 0 0", alu_ctrl, alu_d1);
    end
  endtask

  task automatic test_sum();
    int lat;
    send(32'd5, 32'd7, 1'b1, 3'b001, 5'd3);
    wait_rsp(lat);
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL sum_latency got %0d exp 3", lat);
    end
    checks++;
    if (rsp_data !== 32'd12 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL sum_data got %0d z %0b exp 12 z 0", rsp_data, rsp_zero);
    end
    checks++;
    if (rsp_tag !== 5'd3 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL sum_tag got %0d e %0b exp 3 e 0", rsp_tag, rsp_err);
    end
    checks++;
    if (alu_ctrl !== 3'b001) begin
      errors++; $display("FAIL sum_ctrl got %0b exp 001", alu_ctrl);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL sum_drain got %0b exp 0", rsp_valid);
    end
  endtask

  task automatic test_sub_mul();
    int lat, c1, c2;
    send(32'd9, 32'd9, 1'b1, 3'b010, 5'd1);
    send(32'd6, 32'd7, 1'b1, 3'b011, 5'd2);
    wait_rsp(lat);
    c1 = cyc;
    checks++;
    if (lat < 0 || rsp_data !== 32'd0 || rsp_zero !== 1'b1
        || rsp_tag !== 5'd1) begin
      errors++;
      $display("FAIL sub_rsp got %0d z %0b t %0d exp 0 z 1 t 1",
               rsp_data, rsp_zero, rsp_tag);
    end
    wait_rsp(lat);
    c2 = cyc;
    checks++;
    if (lat < 0 || rsp_data !== 32'd42 || rsp_zero !== 1'b0
        || rsp_tag !== 5'd2) begin
      errors++;
      $display("FAIL mul_rsp got %0d z %0b t %0d exp 42 z 0 t 2",
               rsp_data, rsp_zero, rsp_tag);
    end
    checks++;
    if (c2 - c1 !== 4) begin
      errors++; $display("FAIL sub_mul_gap got %0d exp 4", c2 - c1);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int acc, expt;
    logic ok, sent5;
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12 && acc < 5; c++) begin
      req_d1 = acc; req_d2 = 32'd10; req_type = 1'b1;
      req_op = 3'b001; req_tag = 5'(acc); req_valid = 1'b1;
      ok = req_ready;
      step();
      if (ok) acc++;
    end
    req_d1 = 32'd5; req_tag = 5'd5;
    checks++;
    if (acc !== 5 || req_ready !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL full got acc %0d rdy %0b cnt %0d exp 5 0 4",
               acc, req_ready, count);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_tag !== 5'd0
          || rsp_data !== 32'd10 || count !== 3'd4) begin
        errors++;
        $display("FAIL stall_hold got v %0b t %0d d %0d c %0d exp 1 0 10 4",
                 rsp_valid, rsp_tag, rsp_data, count);
      end
      step();
    end
    rsp_ready = 1'b1;
    expt = 0;
    sent5 = 1'b0;
    for (int c = 0; c < 60 && (expt < 6 || !sent5); c++) begin
      ok = req_ready && req_valid;
      if (rsp_valid) begin
        checks++;
        if (rsp_tag !== 5'(expt) || rsp_data !== 32'(expt + 10)) begin
          errors++;
          $display("FAIL order got t %0d d %0d exp t %0d d %0d",
                   rsp_tag, rsp_data, expt, expt + 10);
        end
        expt++;
      end
      step();
      if (ok) begin
        sent5 = 1'b1;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (expt !== 6 || sent5 !== 1'b1) begin
      errors++;
      $display("FAIL drain_all got %0d sent %0b exp 6 1", expt, sent5);
    end
  endtask

  task automatic test_invalid();
    int lat;
    step(); step();
    send(32'd1, 32'd2, 1'b1, 3'b111, 5'd9);
    wait_rsp(lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL inv_latency got %0d exp 1", lat);
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_data !== 32'd0 || rsp_tag !== 5'd9
        || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL inv_rsp got e %0b d %0h t %0d exp 1 0 9",
               rsp_err, rsp_data, rsp_tag);
    end
    checks++;
    if (alu_ctrl !== 3'b001 || alu_d1 !== 32'd5) begin
      errors++;
      $display("FAIL inv_alu got ctrl %0b d1 %0d exp 001 5", alu_ctrl, alu_d1);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    send(32'd3, 32'd1, 1'b1, 3'b010, 5'd4);
    send(32'd1, 32'd1, 1'b1, 3'b001, 5'd5);
    send(32'd2, 32'd2, 1'b1, 3'b001, 5'd6);
    checks++;
    if (count !== 3'd2 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_rst got cnt %0d v %0b exp 2 0", count, rsp_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || count !== 3'd0 || req_ready !== 1'b1
        || alu_ctrl !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst got v %0b c %0d r %0b ctrl %0b exp 0 0 1 0",
               rsp_valid, count, req_ready, alu_ctrl);
    end
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL dropped_rsp got %0d exp 0", seen);
    end
  endtask

  task automatic test_div();
    int lat;
    send(32'd10, 32'd2, 1'b1, 3'b100, 5'd7);
    wait_rsp(lat);
    checks++;
    if (lat !== 3 || rsp_data !== 32'd5 || rsp_err !== 1'b0
        || rsp_tag !== 5'd7) begin
      errors++;
      $display("FAIL div_ok got l %0d d %0d e %0b t %0d exp 3 5 0 7",
               lat, rsp_data, rsp_err, rsp_tag);
    end
    step();
    send(32'd10, 32'd0, 1'b1, 3'b100, 5'd8);
    wait_rsp(lat);
`ifdef ALU_DIV0_TRAP_EN
    checks++;
    if (lat !== 1 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL div0_trap got l %0d e %0b exp 1 1", lat, rsp_err);
    end
`else
    checks++;
    if (lat !== 3 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL div0_issue got l %0d e %0b exp 3 0", lat, rsp_err);
    end
`endif
    checks++;
    if (rsp_data !== 32'hFFFF_FFFF || rsp_tag !== 5'd8) begin
      errors++;
      $display("FAIL div0_data got %0h t %0d exp ffffffff 8",
               rsp_data, rsp_tag);
    end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_sum();
    test_sub_mul();
    test_back_to_back();
    test_invalid();
    test_reset_mid();
    test_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
